// File: rtl/uart_pkg.sv
// Shared types and constants for the UART FIFO core.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int MIN_CLKS_PER_BIT = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO; pointers carry one extra MSB
// so full and empty are told apart without a separate count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the head slot in the same cycle, so a push on a full FIFO
  // still lands when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone
  // decide validity, and unreset memory maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_fifo_core.sv
// UART transmitter and receiver, each buffered by a uart_sync_fifo.
// Define UART_PARITY_EN to add an even-parity bit and the rx_parity_err port.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_enable,
  output logic              tx_out,
  output logic              tx_empty,
  output logic              tx_full,
  input  logic              uld_rx_data,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_enable,
  input  logic              rx_in,
  output logic              rx_empty,
  output logic              rx_overrun,
  output logic              rx_frame_err
`ifdef UART_PARITY_EN
  ,
  output logic              rx_parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks
    $error("uart_fifo_core: CLKS_PER_BIT must be even and >= %0d", MIN_CLKS_PER_BIT);
  end

  // ---------------------------------------------------------------- TX path
  uart_state_e       tx_state, tx_state_n;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_n;
  logic [BIT_W-1:0]  tx_bit, tx_bit_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic [DATA_W-1:0] tx_head;
  logic              tx_out_n;
  logic              tx_pop;
  logic              tx_fifo_empty;
  logic              tx_start;
`ifdef UART_PARITY_EN
  logic              tx_par, tx_par_n;
`endif

  uart_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ld_tx_data),
    .pop   (tx_pop),
    .wdata (tx_data),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_fifo_empty)
  );

  assign tx_start = tx_enable && !tx_fifo_empty;
  assign tx_empty = tx_fifo_empty && (tx_state == ST_IDLE);

  // tx_out_n is the line level for the cycle after this edge, which keeps
  // tx_out a clean register while the start bit lands on the pop edge.
  // NOTE: every always_comb output gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_out_n   = tx_out;
    tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      ST_IDLE: begin
        tx_cnt_n = '0;
        tx_out_n = 1'b1;
        if (tx_start) begin
          tx_pop     = 1'b1;
          tx_state_n = ST_START;
          tx_shift_n = tx_head;
          tx_out_n   = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_n   = ^tx_head;
`endif
        end
      end
      ST_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = ST_DATA;
          tx_out_n   = tx_shift[0];
        end
      end
      ST_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_n = ST_PARITY;
            tx_out_n   = tx_par;
`else
            tx_state_n = ST_STOP;
            tx_out_n   = 1'b1;
`endif
          end else begin
            tx_bit_n   = tx_bit + 1'b1;
            tx_shift_n = tx_shift >> 1;
            tx_out_n   = tx_shift[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = ST_STOP;
          tx_out_n   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          // Chain straight into the next start bit when more data waits.
          if (tx_start) begin
            tx_pop     = 1'b1;
            tx_state_n = ST_START;
            tx_shift_n = tx_head;
            tx_out_n   = 1'b0;
`ifdef UART_PARITY_EN
            tx_par_n   = ^tx_head;
`endif
          end else begin
            tx_state_n = ST_IDLE;
            tx_out_n   = 1'b1;
          end
        end
      end
      default: begin
        tx_state_n = ST_IDLE;
        tx_out_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_out   <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_out   <= tx_out_n;
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // ---------------------------------------------------------------- RX path
  uart_state_e       rx_state, rx_state_n;
  logic [CNT_W-1:0]  rx_cnt, rx_cnt_n;
  logic [BIT_W-1:0]  rx_bit, rx_bit_n;
  logic [DATA_W-1:0] rx_shift, rx_shift_n;
  logic              rx_s1, rx_s2, rx_prev;
  logic              rx_fall;
  logic              rx_push_q, rx_push_n;
  logic              rx_frame_err_n;
  logic              rx_fifo_full;
`ifdef UART_PARITY_EN
  logic              rx_par_bad, rx_par_bad_n;
  logic              rx_parity_err_n;
`endif

  assign rx_fall = rx_prev && !rx_s2;

  always_comb begin
    rx_state_n     = rx_state;
    rx_cnt_n       = rx_cnt + 1'b1;
    rx_bit_n       = rx_bit;
    rx_shift_n     = rx_shift;
    rx_push_n      = 1'b0;
    rx_frame_err_n = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_n    = rx_par_bad;
    rx_parity_err_n = 1'b0;
`endif
    case (rx_state)
      ST_IDLE: begin
        rx_cnt_n = '0;
        if (rx_enable && rx_fall) rx_state_n = ST_START;
      end
      ST_START: begin
        // Mid-bit check: a line already back high was only a glitch.
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[DATA_W-1:1]};
          if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_n = ST_PARITY;
`else
            rx_state_n = ST_STOP;
`endif
          end else begin
            rx_bit_n = rx_bit + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n        = '0;
          rx_par_bad_n    = rx_s2 ^ (^rx_shift);
          rx_parity_err_n = rx_s2 ^ (^rx_shift);
          rx_state_n      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = ST_IDLE;
          if (!rx_s2) begin
            rx_frame_err_n = 1'b1;
          end else begin
`ifdef UART_PARITY_EN
            rx_push_n = !rx_par_bad;
`else
            rx_push_n = 1'b1;
`endif
          end
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

  // Synchroniser flops reset high so the idle line raises no false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= ST_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_push_q    <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_s1        <= rx_in;
      rx_s2        <= rx_s1;
      rx_prev      <= rx_s2;
      rx_state     <= rx_state_n;
      rx_cnt       <= rx_cnt_n;
      rx_bit       <= rx_bit_n;
      rx_shift     <= rx_shift_n;
      rx_push_q    <= rx_push_n;
      rx_frame_err <= rx_frame_err_n;
`ifdef UART_PARITY_EN
      rx_par_bad    <= rx_par_bad_n;
      rx_parity_err <= rx_parity_err_n;
`endif
    end
  end

  // rx_shift holds the finished word while rx_push_q is high.
  uart_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push_q),
    .pop   (uld_rx_data),
    .wdata (rx_shift),
    .rdata (rx_data),
    .full  (rx_fifo_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun <= 1'b0;
    end else if (rx_push_q && rx_fifo_full && !uld_rx_data) begin
      rx_overrun <= 1'b1;
    end
  end

endmodule

// File: doc/uart_fifo_core.md
UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W, default 8, SHALL set data bits per frame (legal 5..9).
REQ-003 Parameter CLKS_PER_BIT, default 16, SHALL set clk cycles per bit (legal >= 4, even).
REQ-004 Parameter TX_DEPTH, default 4, SHALL set TX FIFO entries (power of 2, >= 2).
REQ-005 Parameter RX_DEPTH, default 4, SHALL set RX FIFO entries (power of 2, >= 2).
REQ-006 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- ld_tx_data  in  1  push tx_data into TX FIFO
- tx_data  in  DATA_W  TX word
- tx_enable  in  1  allow new TX frames to start
- tx_out  out  1  serial line, idle high
- tx_empty  out  1  TX FIFO empty and TX FSM idle
- tx_full  out  1  TX FIFO full
- uld_rx_data  in  1  pop RX FIFO head
- rx_data  out  DATA_W  RX FIFO head (first-word fall-through)
- rx_enable  in  1  allow new RX frames to start
- rx_in  in  1  asynchronous serial input
- rx_empty  out  1  RX FIFO empty
- rx_overrun  out  1  sticky: frame lost to full RX FIFO
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low

Function
REQ-007 Frame: 1 start bit (0), DATA_W data bits LSB first, optional parity bit, 1 stop bit (1); each bit CLKS_PER_BIT cycles.
REQ-008 ld_tx_data with tx_full=0 SHALL write; with tx_full=1 SHALL be dropped, FIFO unchanged.
REQ-009 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START when tx_enable=1 and FIFO non-empty, popping the head on that edge.
REQ-010 tx_out SHALL be registered and go low on the 2nd rising edge after an ld_tx_data edge into an empty, idle, enabled TX path.
REQ-011 STOP->START directly if tx_enable=1 and FIFO non-empty (no idle gap), else STOP->IDLE; tx_enable=0 mid-frame SHALL NOT abort the frame.
REQ-012 rx_in SHALL pass through a 2-flop synchroniser before use.
REQ-013 RX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronised falling edge when rx_enable=1.
REQ-014 Start bit sampled at CLKS_PER_BIT/2; if high, SHALL return to IDLE (glitch reject), no error; later bits sampled every CLKS_PER_BIT.
REQ-015 Stop sampled low: rx_frame_err pulses 1 cycle, word discarded, FSM to IDLE.
REQ-016 Good word SHALL be written to RX FIFO the cycle after the stop sample; rx_empty falls 1 cycle later.
REQ-017 Good word with RX FIFO full SHALL be discarded and set rx_overrun, cleared only by reset; FIFO contents preserved.
REQ-018 uld_rx_data with rx_empty=1 SHALL be ignored.
REQ-019 Simultaneous push and pop on a full FIFO SHALL both succeed; no overrun, no drop.
REQ-020 Both FIFO pointers SHALL wrap modulo depth; full/empty from an extra pointer MSB.

Reset
REQ-021 Reset SHALL empty both FIFOs, put both FSMs in IDLE, and drive tx_out=1, tx_empty=1, tx_full=0, rx_empty=1, rx_overrun=0, rx_frame_err=0, rx_data=0.
REQ-022 Reset mid-frame SHALL abort; tx_out=1 from the first cycle after the reset edge.

Configuration
REQ-023 Macro UART_PARITY_EN defined: even-parity bit sent/checked after data; output rx_parity_err (1 bit, one-cycle pulse) added, bad-parity word discarded.
REQ-024 UART_PARITY_EN undefined: PARITY states unreachable, no parity bit, no rx_parity_err port.

Structure
REQ-025 Package uart_pkg SHALL hold the TX/RX state enum and the minimum CLKS_PER_BIT constant.
REQ-026 Both FIFOs SHALL be instances of one sub-module, uart_sync_fifo (params WIDTH, DEPTH).

Verification (DATA_W=8, CLKS_PER_BIT=4, depths 4, tx_out looped to rx_in)
REQ-027 Send 0xA5 then 0x3C -> rx_data pops 0xA5, 0x3C; each frame 40 cycles (44 with parity), back-to-back.
REQ-028 tx_enable=0, write 5 words -> tx_full=1 after 4th, 5th dropped; tx_enable=1 -> exactly 4 frames.
REQ-029 Drive frame 0x55 with stop bit 0 -> one-cycle rx_frame_err, rx_empty stays 1.
REQ-030 Receive 5 frames without uld_rx_data -> rx_overrun=1, first 4 words intact; 2-cycle low glitch on rx_in -> no word, no error.
REQ-031 Reset during DATA of 0xFF -> tx_out=1 next cycle, tx_empty=1, rx_empty=1.
REQ-032 UART_PARITY_EN: send 0x07 -> parity bit 1; flip it -> rx_parity_err pulse, word dropped.
